kv_cmd_sequencer: RTL and testbench



---
 rtl/kv_cmd_pkg.sv | 38 +++
 rtl/kv_rsp_serializer.sv | 40 ++++
 rtl/kv_cmd_sequencer.sv | 193 +++++++++++++++++++
 tb/tb_kv_cmd_sequencer.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/kv_cmd_pkg.sv
// Shared opcodes, status codes, FSM state and operand-count helper for the
// key-value command sequencer.
package kv_cmd_pkg;

  localparam logic [7:0] OP_PAD      = 8'h00;
  localparam logic [7:0] OP_SET      = 8'h01;
  localparam logic [7:0] OP_GET      = 8'h02;
  localparam logic [7:0] OP_TRANSFER = 8'h03;

  localparam logic [1:0] CMD_NONE     = 2'd0;
  localparam logic [1:0] CMD_SET      = 2'd1;
  localparam logic [1:0] CMD_GET      = 2'd2;
  localparam logic [1:0] CMD_TRANSFER = 2'd3;

  localparam logic [7:0] ST_OK       = 8'h00;
  localparam logic [7:0] ST_EXEC_ERR = 8'h10;
  localparam logic [7:0] ST_BAD_OP   = 8'hE0;
  localparam logic [7:0] ST_TIMEOUT  = 8'hE1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_OPERANDS,
    S_ISSUE,
    S_WAIT_DONE,
    S_RESPOND
  } state_e;

  // Zero marks an opcode that is not recognised.
  function automatic logic [2:0] opnd_count(input logic [7:0] op);
    case (op)
      OP_SET:      return 3'd3;
      OP_GET:      return 3'd1;
      OP_TRANSFER: return 3'd4;
      default:     return 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/kv_rsp_serializer.sv
// Loads a status byte plus optional 16-bit data and shifts them out MSB-first
// on a valid/ready byte interface; last_o flags the final byte handshake.
module kv_rsp_serializer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ld_i,
  input  logic [7:0]  ld_status_i,
  input  logic        ld_has_data_i,
  input  logic [15:0] ld_data_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [7:0]  rsp_byte_o,
  output logic        last_o
);

  logic [23:0] sh_q;
  logic [1:0]  rem_q;
  logic        vld_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_q  <= '0;
      rem_q <= '0;
      vld_q <= 1'b0;
    end else if (ld_i) begin
      sh_q  <= {ld_status_i, ld_data_i};
      rem_q <= ld_has_data_i ? 2'd3 : 2'd1;
      vld_q <= 1'b1;
    end else if (vld_q && rsp_ready_i) begin
      sh_q  <= {sh_q[15:0], 8'h00};
      rem_q <= rem_q - 2'd1;
      vld_q <= (rem_q != 2'd1);
    end
  end

  assign rsp_valid_o = vld_q;
  assign rsp_byte_o  = sh_q[23:16];
  assign last_o      = vld_q && rsp_ready_i && (rem_q == 2'd1);

endmodule

// File: rtl/kv_cmd_sequencer.sv
// Byte-stream front end for SET/GET/TRANSFER: decode, issue one command, wait
// for completion, stream status/result. Optional stall timeout: KV_CMD_TIMEOUT_EN.
module kv_cmd_sequencer
  import kv_cmd_pkg::*;
#(
  parameter int KEY_W          = 8,
  parameter int VAL_W          = 16,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [7:0]       in_byte_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  output logic             cmd_valid_o,
  input  logic             cmd_ready_i,
  output logic [1:0]       cmd_op_o,
  output logic [KEY_W-1:0] cmd_key_a_o,
  output logic [KEY_W-1:0] cmd_key_b_o,
  output logic [VAL_W-1:0] cmd_value_o,
  input  logic             exec_done_i,
  input  logic [1:0]       exec_status_i,
  input  logic [VAL_W-1:0] exec_rdata_i,
  output logic             rsp_valid_o,
  input  logic             rsp_ready_i,
  output logic [7:0]       rsp_byte_o,
  output logic             busy_o
);

  state_e           state_q;
  logic             in_ready_q, busy_q, cmd_valid_q;
  logic [1:0]       op_q;
  logic [2:0]       cnt_q;
  logic [23:0]      opnd_q;
  logic [KEY_W-1:0] key_a_q, key_b_q;
  logic [VAL_W-1:0] value_q;

  logic        accept;
  logic [31:0] frame;
  logic        ser_ld, ser_has_data, ser_last;
  logic [7:0]  ser_status;

  assign accept = in_valid_i && in_ready_q;
  // Earlier operand bytes plus the byte being accepted now.
  assign frame  = {opnd_q, in_byte_i};

`ifdef KV_CMD_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tmo_q;
  logic          tmo_hit;

  assign tmo_hit = (tmo_q == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                             tmo_q <= '0;
    else if (state_q != S_OPERANDS || accept) tmo_q <= '0;
    else                                    tmo_q <= tmo_q + 1'b1;
  end
`endif

  // Response load strobe; the FSM enters RESPOND on the same edge.
  always_comb begin
    ser_ld       = 1'b0;
    ser_status   = ST_OK;
    ser_has_data = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept && in_byte_i != OP_PAD && opnd_count(in_byte_i) == 3'd0) begin
          ser_ld     = 1'b1;
          ser_status = ST_BAD_OP;
        end
      end
      S_OPERANDS: begin
`ifdef KV_CMD_TIMEOUT_EN
        if (!accept && tmo_hit) begin
          ser_ld     = 1'b1;
          ser_status = ST_TIMEOUT;
        end
`endif
      end
      S_WAIT_DONE: begin
        if (exec_done_i) begin
          ser_ld       = 1'b1;
          ser_status   = (exec_status_i == 2'd0) ? ST_OK : (ST_EXEC_ERR | {6'b0, exec_status_i});
          ser_has_data = (op_q == CMD_GET) && (exec_status_i == 2'd0);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      in_ready_q  <= 1'b0;
      busy_q      <= 1'b0;
      cmd_valid_q <= 1'b0;
      op_q        <= CMD_NONE;
      cnt_q       <= '0;
      opnd_q      <= '0;
      key_a_q     <= '0;
      key_b_q     <= '0;
      value_q     <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          in_ready_q <= 1'b1;
          if (ser_ld) begin
            state_q    <= S_RESPOND;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
          end else if (accept && in_byte_i != OP_PAD) begin
            op_q    <= in_byte_i[1:0];
            cnt_q   <= opnd_count(in_byte_i);
            opnd_q  <= '0;
            state_q <= S_OPERANDS;
            busy_q  <= 1'b1;
          end
        end
        S_OPERANDS: begin
          if (ser_ld) begin
            state_q    <= S_RESPOND;
            in_ready_q <= 1'b0;
          end else if (accept) begin
            opnd_q <= frame[23:0];
            cnt_q  <= cnt_q - 3'd1;
            if (cnt_q == 3'd1) begin
              state_q     <= S_ISSUE;
              in_ready_q  <= 1'b0;
              cmd_valid_q <= 1'b1;
              case (op_q)
                CMD_SET: begin
                  key_a_q <= KEY_W'(frame[23:16]);
                  key_b_q <= '0;
                  value_q <= VAL_W'(frame[15:0]);
                end
                CMD_GET: begin
                  key_a_q <= KEY_W'(frame[7:0]);
                  key_b_q <= '0;
                  value_q <= '0;
                end
                default: begin
                  key_a_q <= KEY_W'(frame[31:24]);
                  key_b_q <= KEY_W'(frame[23:16]);
                  value_q <= VAL_W'(frame[15:0]);
                end
              endcase
            end
          end
        end
        S_ISSUE: begin
          if (cmd_ready_i) begin
            cmd_valid_q <= 1'b0;
            state_q     <= S_WAIT_DONE;
          end
        end
        S_WAIT_DONE: begin
          if (ser_ld) state_q <= S_RESPOND;
        end
        S_RESPOND: begin
          if (ser_last) begin
            state_q    <= S_IDLE;
            in_ready_q <= 1'b1;
            busy_q     <= 1'b0;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  kv_rsp_serializer u_rsp (
    .clk          (clk),
    .rst_n        (rst_n),
    .ld_i         (ser_ld),
    .ld_status_i  (ser_status),
    .ld_has_data_i(ser_has_data),
    .ld_data_i    (16'(exec_rdata_i)),
    .rsp_valid_o  (rsp_valid_o),
    .rsp_ready_i  (rsp_ready_i),
    .rsp_byte_o   (rsp_byte_o),
    .last_o       (ser_last)
  );

  assign in_ready_o  = in_ready_q;
  assign busy_o      = busy_q;
  assign cmd_valid_o = cmd_valid_q;
  assign cmd_op_o    = op_q;
  assign cmd_key_a_o = key_a_q;
  assign cmd_key_b_o = key_b_q;
  assign cmd_value_o = value_q;

endmodule

// File: tb/tb_kv_cmd_sequencer.sv
// Directed scoreboard bench for kv_cmd_sequencer; the timeout step is built
// only when KV_CMD_TIMEOUT_EN is defined.
module tb_kv_cmd_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  in_byte = 8'h00;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        cmd_valid;
  logic        cmd_ready = 1'b1;
  logic [1:0]  cmd_op;
  logic [7:0]  cmd_key_a, cmd_key_b;
  logic [15:0] cmd_value;
  logic        exec_done = 1'b0;
  logic [1:0]  exec_status = 2'd0;
  logic [15:0] exec_rdata = 16'h0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [7:0]  rsp_byte;
  logic        busy;

  int errors = 0;
  int checks = 0;
  int cmd_cnt = 0;
  logic [33:0] exp_cmd[$];
  logic [7:0]  exp_rsp[$];

  kv_cmd_sequencer #(.KEY_W(8), .VAL_W(16), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_byte_i(in_byte), .in_valid_i(in_valid), .in_ready_o(in_ready),
    .cmd_valid_o(cmd_valid), .cmd_ready_i(cmd_ready), .cmd_op_o(cmd_op),
    .cmd_key_a_o(cmd_key_a), .cmd_key_b_o(cmd_key_b), .cmd_value_o(cmd_value),
    .exec_done_i(exec_done), .exec_status_i(exec_status), .exec_rdata_i(exec_rdata),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_byte_o(rsp_byte),
    .busy_o(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [33:0] mk_cmd(input logic [1:0] op, input logic [7:0] ka,
                                         input logic [7:0] kb, input logic [15:0] v);
    return {op, ka, kb, v};
  endfunction

  // Scoreboard: pop expected items on each observed handshake.
  always @(negedge clk) begin
    if (rst_n) begin
      if (cmd_valid && cmd_ready) begin
        cmd_cnt++;
        if (exp_cmd.size() == 0) chk("cmd_unexpected", 64'(exp_cmd.size()), 64'd1);
        else chk("cmd_fields", {cmd_op, cmd_key_a, cmd_key_b, cmd_value}, exp_cmd.pop_front());
      end
      if (rsp_valid && rsp_ready) begin
        if (exp_rsp.size() == 0) chk("rsp_unexpected", 64'(exp_rsp.size()), 64'd1);
        else chk("rsp_byte", rsp_byte, exp_rsp.pop_front());
      end
    end
  end

  task automatic send(input logic [7:0] b);
    bit ok = 1'b0;
    in_byte  = b;
    in_valid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1'b1; break; end
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("send_ready", ok, 1'b1);
  endtask

  task automatic wait_cmd(input bit spurious);
    bit ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (cmd_valid && cmd_ready) begin
        ok = 1'b1;
        if (spurious) begin exec_done = 1'b1; exec_status = 2'd3; end
        break;
      end
    end
    @(posedge clk); #1;
    exec_done = 1'b0;
    exec_status = 2'd0;
    chk("cmd_wait", ok, 1'b1);
  endtask

  task automatic pulse_done(input int gap, input logic [1:0] st, input logic [15:0] rd);
    repeat (gap) begin @(posedge clk); #1; end
    chk("busy_wait_done", busy, 1'b1);
    exec_done = 1'b1; exec_status = st; exec_rdata = rd;
    @(posedge clk); #1;
    exec_done = 1'b0; exec_status = 2'd0; exec_rdata = 16'h0;
  endtask

  task automatic drain();
    bit ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (exp_rsp.size() == 0 && !rsp_valid) begin ok = 1'b1; break; end
    end
    chk("drain", ok, 1'b1);
    chk("idle_busy", busy, 1'b0);
    chk("idle_in_ready", in_ready, 1'b1);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    // Reset state
    #1;
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1'b0);
    chk("rst_cmd_valid", cmd_valid, 1'b0);
    chk("rst_rsp_valid", rsp_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (2) @(posedge clk); #1;
    @(negedge clk);
    chk("post_rst_in_ready", in_ready, 1'b1);
    chk("post_rst_busy", busy, 1'b0);
    @(posedge clk); #1;

    // SET: status-only response, rdata ignored
    exp_cmd.push_back(mk_cmd(2'd1, 8'h05, 8'h00, 16'h1234));
    exp_rsp.push_back(8'h00);
    send(8'h01); send(8'h05); send(8'h12); send(8'h34);
    wait_cmd(1'b0);
    pulse_done(3, 2'd0, 16'hAAAA);
    drain();

    // GET with response backpressure after the status byte
    exp_cmd.push_back(mk_cmd(2'd2, 8'h07, 8'h00, 16'h0000));
    exp_rsp.push_back(8'h00); exp_rsp.push_back(8'hBE); exp_rsp.push_back(8'hEF);
    send(8'h02); send(8'h07);
    wait_cmd(1'b0);
    rsp_ready = 1'b0;
    pulse_done(1, 2'd0, 16'hBEEF);
    @(negedge clk);
    chk("rsp_latency", rsp_valid, 1'b1);
    @(posedge clk); #1 rsp_ready = 1'b1;
    @(posedge clk); #1 rsp_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_rsp_valid", rsp_valid, 1'b1);
      chk("stall_rsp_byte", rsp_byte, 8'hBE);
    end
    @(posedge clk); #1 rsp_ready = 1'b1;
    drain();

    // TRANSFER with command backpressure and an exec error
    cmd_ready = 1'b0;
    exp_cmd.push_back(mk_cmd(2'd3, 8'h01, 8'h02, 16'd100));
    exp_rsp.push_back(8'h12);
    send(8'h03); send(8'h01); send(8'h02); send(8'h00); send(8'h64);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("hold_cmd_valid", cmd_valid, 1'b1);
      chk("hold_cmd", {cmd_op, cmd_key_a, cmd_key_b, cmd_value}, mk_cmd(2'd3, 8'h01, 8'h02, 16'd100));
      chk("hold_in_ready", in_ready, 1'b0);
    end
    @(posedge clk); #1 cmd_ready = 1'b1;
    wait_cmd(1'b0);
    pulse_done(2, 2'd2, 16'h5555);
    drain();

    // Padding and bad opcode, then GET with a done pulse on the issue edge
    c0 = cmd_cnt;
    exp_rsp.push_back(8'hE0);
    send(8'h00); send(8'h00); send(8'h7F);
    drain();
    chk("bad_op_no_cmd", cmd_cnt - c0, 0);
    exp_cmd.push_back(mk_cmd(2'd2, 8'h03, 8'h00, 16'h0000));
    exp_rsp.push_back(8'h00); exp_rsp.push_back(8'h01); exp_rsp.push_back(8'h02);
    send(8'h02); send(8'h03);
    wait_cmd(1'b1);
    pulse_done(0, 2'd0, 16'h0102);
    drain();

    // Reset mid-frame
    c0 = cmd_cnt;
    send(8'h03); send(8'h01);
    rst_n = 1'b0;
    #1;
    chk("midrst_in_ready", in_ready, 1'b0);
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_key_a", cmd_key_a, 8'h00);
    chk("midrst_rsp", {rsp_valid, rsp_byte, cmd_valid}, 10'h0);
    repeat (2) @(posedge clk); #1 rst_n = 1'b1;
    repeat (3) @(posedge clk); #1;
    chk("midrst_no_cmd", cmd_cnt - c0, 0);
    exp_cmd.push_back(mk_cmd(2'd2, 8'h09, 8'h00, 16'h0000));
    exp_rsp.push_back(8'h00); exp_rsp.push_back(8'hCA); exp_rsp.push_back(8'hFE);
    send(8'h02); send(8'h09);
    wait_cmd(1'b0);
    pulse_done(2, 2'd0, 16'hCAFE);
    drain();

`ifdef KV_CMD_TIMEOUT_EN
    // Stalled frame times out
    c0 = cmd_cnt;
    exp_rsp.push_back(8'hE1);
    send(8'h01); send(8'h05);
    repeat (16) @(posedge clk); #1;
    drain();
    chk("timeout_no_cmd", cmd_cnt - c0, 0);
`endif

    chk("sb_cmd_empty", 64'(exp_cmd.size()), 64'd0);
    chk("sb_rsp_empty", 64'(exp_rsp.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
